// File: rtl/enc_cw_buffer_pkg.sv
// Shared sizing, symbol/beat types and bank state encoding for the RS encoder codeword buffer.
package enc_pkg;
    localparam int EGF_DIM       = 8;
    localparam int ENC_SYM       = 4;
    localparam int RSC_MES_LEN   = 16;
    localparam int RSC_PAR_LEN   = 8;
    localparam int RSC_MES_BEATS = RSC_MES_LEN / ENC_SYM;
    localparam int RSC_PAR_BEATS = RSC_PAR_LEN / ENC_SYM;
    localparam int RSC_BW        = $clog2(RSC_MES_BEATS + 1);

    typedef logic [EGF_DIM-1:0] sym_t;
    typedef sym_t [ENC_SYM-1:0] beat_t;

    typedef enum logic [2:0] {FREE, FILL, WAIT_PAR, FULL, DRAIN} bank_state_t;
endpackage

// File: rtl/enc_cw_buffer_if.sv
// Write (generator + parity), read (valid/ready beat stream) and status signals of the codeword buffer.
interface enc_cw_buffer_if
    import enc_pkg::*;
#(
    parameter int SYM_W   = EGF_DIM,
    parameter int LANES   = ENC_SYM,
    parameter int PAR_LEN = RSC_PAR_LEN,
    parameter int BW      = RSC_BW
);
    logic [BW-1:0]            cfg_mes_beats;
    logic                     gen_valid;
    logic                     gen_ready;
    logic [LANES*SYM_W-1:0]   gen_data;
    logic                     pro_valid;
    logic [PAR_LEN*SYM_W-1:0] pro_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*SYM_W-1:0]   out_data;
    logic                     out_sop;
    logic                     out_eop;
    logic                     par_err;

    modport slave (
        input  cfg_mes_beats, gen_valid, gen_data, pro_valid, pro_data, out_ready,
        output gen_ready, out_valid, out_data, out_sop, out_eop, par_err
    );

    modport master (
        output cfg_mes_beats, gen_valid, gen_data, pro_valid, pro_data, out_ready,
        input  gen_ready, out_valid, out_data, out_sop, out_eop, par_err
    );
endinterface

// File: rtl/enc_cw_buffer_bank.sv
// One codeword bank: message beats, parity vector, latched length and FREE..DRAIN state.
// Read mux is combinational on the shared beat index; parity lanes are reordered highest symbol first.
module enc_cw_bank
    import enc_pkg::*;
#(
    parameter int SYM_W     = EGF_DIM,
    parameter int LANES     = ENC_SYM,
    parameter int MES_BEATS = RSC_MES_BEATS,
    parameter int PAR_BEATS = RSC_PAR_BEATS,
    parameter int BW        = $clog2(MES_BEATS + 1),
    parameter int IW        = $clog2(MES_BEATS + PAR_BEATS),
    parameter int AW        = (MES_BEATS > 1) ? $clog2(MES_BEATS) : 1
)(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_wr_en,
    input  logic [BW-1:0]                      i_wr_cnt,
    input  logic [LANES*SYM_W-1:0]             i_wr_dat,
    input  logic                               i_par_en,
    input  logic [PAR_BEATS*LANES*SYM_W-1:0]   i_par_dat,
    input  logic                               i_drain_start,
    input  logic                               i_free,
    input  logic [IW-1:0]                      i_rd_idx,
    output bank_state_t                        o_state,
    output bank_state_t                        o_state_nxt,
    output logic                               o_fill_done,
    output logic [IW-1:0]                      o_last_idx,
    output logic [LANES*SYM_W-1:0]             o_rd_dat
);
    localparam int PAR_LEN = PAR_BEATS * LANES;

    logic [LANES*SYM_W-1:0]   r_mem [MES_BEATS];
    logic [PAR_LEN*SYM_W-1:0] r_par;
    logic [BW-1:0]            r_cnt;
    logic [BW-1:0]            r_widx;
    bank_state_t              r_state;
    bank_state_t              w_nxt;
    logic [BW-1:0]            w_cnt;
    logic                     w_wr;
    logic                     w_last;

    // The beat count is taken live on the first beat and from the latch thereafter.
    assign w_cnt       = (r_state == FREE) ? i_wr_cnt : r_cnt;
    assign w_wr        = i_wr_en && (r_state == FREE || r_state == FILL);
    assign w_last      = (r_widx == w_cnt - BW'(1));
    assign o_fill_done = w_wr && w_last;
    assign o_state     = r_state;
    assign o_state_nxt = w_nxt;
    assign o_last_idx  = IW'(r_cnt) + IW'(PAR_BEATS - 1);

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            FREE, FILL: if (i_wr_en) w_nxt = !w_last ? FILL : (i_par_en ? FULL : WAIT_PAR);
            WAIT_PAR:   if (i_par_en) w_nxt = FULL;
            FULL:       if (i_drain_start) w_nxt = DRAIN;
            DRAIN:      if (i_free) w_nxt = FREE;
            default:    w_nxt = FREE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FREE;
            r_cnt   <= '0;
            r_widx  <= '0;
            r_par   <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_wr) begin
                if (r_state == FREE) r_cnt <= i_wr_cnt;
                r_widx <= w_last ? '0 : r_widx + BW'(1);
            end
            if (i_par_en) r_par <= i_par_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_widx[AW-1:0]] <= i_wr_dat;
    end

    always_comb begin
        o_rd_dat = '0;
        if (i_rd_idx < IW'(r_cnt)) begin
            o_rd_dat = r_mem[i_rd_idx[AW-1:0]];
        end else begin
            for (int k = 0; k < PAR_BEATS; k++) begin
                if (i_rd_idx == IW'(r_cnt) + IW'(k)) begin
                    for (int j = 0; j < LANES; j++) begin
                        o_rd_dat[j*SYM_W +: SYM_W] = r_par[(PAR_LEN-1-(k*LANES+j))*SYM_W +: SYM_W];
                    end
                end
            end
        end
    end
endmodule

// File: rtl/enc_cw_buffer.sv
// Ping-pong RS codeword assembly: two banks, parity routed to the oldest waiting bank, registered output beat.
// out_sop one cycle after parity capture; output holds under out_ready low, reloads on the accepting edge.
module enc_cw_buffer
    import enc_pkg::*;
#(
    parameter int SYM_W   = EGF_DIM,
    parameter int LANES   = ENC_SYM,
    parameter int MES_LEN = RSC_MES_LEN,
    parameter int PAR_LEN = RSC_PAR_LEN
)(
    input  logic            clk,
    input  logic            rst,
    enc_cw_buffer_if.slave  bus
);
    localparam int MES_BEATS = MES_LEN / LANES;
    localparam int PAR_BEATS = PAR_LEN / LANES;
    localparam int BW        = $clog2(MES_BEATS + 1);
    localparam int IW        = $clog2(MES_BEATS + PAR_BEATS);
    localparam int DW        = LANES * SYM_W;

    bank_state_t   w_state     [2];
    bank_state_t   w_state_nxt [2];
    logic [IW-1:0] w_last_idx  [2];
    logic [DW-1:0] w_rd_dat    [2];
    logic [1:0]    w_wr_en, w_par_en, w_fill_done, w_drain_start, w_free;
    logic [BW-1:0] w_cfg;
    logic          w_accept, w_par_hit, w_can_load, w_load, w_wp_nxt, w_ld_last;

    logic          r_wp, r_pp, r_ld, r_out_bank;
    logic          r_gen_rdy, r_par_err;
    logic          r_out_vld, r_out_sop, r_out_eop;
    logic [DW-1:0] r_out_dat;
    logic [IW-1:0] r_beat;

    assign w_cfg = (bus.cfg_mes_beats == '0 || bus.cfg_mes_beats > BW'(MES_BEATS))
                   ? BW'(MES_BEATS) : bus.cfg_mes_beats;
    assign w_accept = bus.gen_valid && r_gen_rdy;
    // Fills and parity both proceed in bank order, so r_pp always names the oldest bank owed parity,
    // including the filling bank when its last beat and the parity pulse coincide.
    assign w_par_hit  = bus.pro_valid && (w_state[r_pp] == WAIT_PAR || w_fill_done[r_pp]);
    assign w_can_load = (w_state[r_ld] == FULL) || (w_state[r_ld] == DRAIN);
    assign w_load     = w_can_load && (!r_out_vld || bus.out_ready);
    assign w_ld_last  = (r_beat == w_last_idx[r_ld]);
    assign w_wp_nxt   = r_wp ^ w_fill_done[r_wp];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign w_wr_en[b]       = w_accept && (r_wp == 1'(b));
        assign w_par_en[b]      = w_par_hit && (r_pp == 1'(b));
        assign w_drain_start[b] = w_load && (r_ld == 1'(b)) && (w_state[b] == FULL);
        assign w_free[b]        = r_out_vld && bus.out_ready && r_out_eop && (r_out_bank == 1'(b));

        enc_cw_bank #(
            .SYM_W(SYM_W), .LANES(LANES), .MES_BEATS(MES_BEATS), .PAR_BEATS(PAR_BEATS),
            .BW(BW), .IW(IW)
        ) u_bank (
            .clk          (clk),
            .rst          (rst),
            .i_wr_en      (w_wr_en[b]),
            .i_wr_cnt     (w_cfg),
            .i_wr_dat     (bus.gen_data),
            .i_par_en     (w_par_en[b]),
            .i_par_dat    (bus.pro_data),
            .i_drain_start(w_drain_start[b]),
            .i_free       (w_free[b]),
            .i_rd_idx     (r_beat),
            .o_state      (w_state[b]),
            .o_state_nxt  (w_state_nxt[b]),
            .o_fill_done  (w_fill_done[b]),
            .o_last_idx   (w_last_idx[b]),
            .o_rd_dat     (w_rd_dat[b])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp       <= 1'b0;
            r_pp       <= 1'b0;
            r_ld       <= 1'b0;
            r_out_bank <= 1'b0;
            r_gen_rdy  <= 1'b0;
            r_par_err  <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_sop  <= 1'b0;
            r_out_eop  <= 1'b0;
            r_out_dat  <= '0;
            r_beat     <= '0;
        end else begin
            r_wp      <= w_wp_nxt;
            r_gen_rdy <= (w_state_nxt[w_wp_nxt] == FREE) || (w_state_nxt[w_wp_nxt] == FILL);
            if (w_par_hit) r_pp <= ~r_pp;
            if (bus.pro_valid && !w_par_hit) r_par_err <= 1'b1;
            if (w_load) begin
                r_out_vld  <= 1'b1;
                r_out_dat  <= w_rd_dat[r_ld];
                r_out_sop  <= (r_beat == '0);
                r_out_eop  <= w_ld_last;
                r_out_bank <= r_ld;
                r_beat     <= w_ld_last ? '0 : r_beat + IW'(1);
                if (w_ld_last) r_ld <= ~r_ld;
            end else if (bus.out_ready) begin
                r_out_vld <= 1'b0;
                r_out_sop <= 1'b0;
                r_out_eop <= 1'b0;
            end
        end
    end

    assign bus.gen_ready = r_gen_rdy;
    assign bus.out_valid = r_out_vld;
    assign bus.out_data  = r_out_dat;
    assign bus.out_sop   = r_out_sop;
    assign bus.out_eop   = r_out_eop;
    assign bus.par_err   = r_par_err;
endmodule

// File: tb/tb_enc_cw_buffer.sv
// Scoreboard bench for enc_cw_buffer: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_enc_cw_buffer;
    import enc_pkg::*;

    localparam int DW = ENC_SYM * EGF_DIM;
    localparam int PW = RSC_PAR_LEN * EGF_DIM;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          sop;
        logic          eop;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    enc_cw_buffer_if #(.SYM_W(EGF_DIM), .LANES(ENC_SYM), .PAR_LEN(RSC_PAR_LEN), .BW(RSC_BW)) bus ();

    enc_cw_buffer #(
        .SYM_W(EGF_DIM), .LANES(ENC_SYM), .MES_LEN(RSC_MES_LEN), .PAR_LEN(RSC_PAR_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   checks     = 0;
    int   failures   = 0;
    int   beats_seen = 0;
    int   fills_done = 0;
    bit   rand_rdy   = 1'b0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [DW-1:0] msg_beat(input logic [7:0] base, input int idx);
        logic [DW-1:0] r;
        for (int j = 0; j < ENC_SYM; j++) r[j*8 +: 8] = base + 8'(idx*ENC_SYM + j);
        return r;
    endfunction

    function automatic logic [PW-1:0] par_vec(input logic [7:0] pbase);
        logic [PW-1:0] r;
        for (int i = 0; i < RSC_PAR_LEN; i++) r[i*8 +: 8] = pbase + 8'(i);
        return r;
    endfunction

    // Parity beat k lane j carries symbol PAR_LEN-1-(k*LANES+j), whose value is pbase plus that index.
    function automatic logic [DW-1:0] par_beat(input logic [7:0] pbase, input int k);
        logic [DW-1:0] r;
        for (int j = 0; j < ENC_SYM; j++) r[j*8 +: 8] = pbase + 8'(RSC_PAR_LEN - 1 - (k*ENC_SYM + j));
        return r;
    endfunction

    task automatic push(input logic [DW-1:0] d, input logic s, input logic e);
        exp_t x;
        x.dat = d; x.sop = s; x.eop = e;
        exp_q.push_back(x);
    endtask

    task automatic push_cw(input logic [7:0] base, input int n, input logic [7:0] pbase);
        for (int i = 0; i < n; i++) push(msg_beat(base, i), i == 0, 1'b0);
        for (int k = 0; k < RSC_PAR_BEATS; k++) push(par_beat(pbase, k), 1'b0, k == RSC_PAR_BEATS - 1);
    endtask

    task automatic put_msg(input logic [7:0] base, input logic [RSC_BW-1:0] cfg, input int n,
                           input bit with_par, input logic [7:0] pbase);
        int t;
        bus.cfg_mes_beats = cfg;
        for (int i = 0; i < n; i++) begin
            bus.gen_valid = 1'b1;
            bus.gen_data  = msg_beat(base, i);
            t = 0;
            while (!bus.gen_ready && t < 300) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 300) begin
                fail("gen_ready_timeout");
                bus.gen_valid = 1'b0;
                return;
            end
            if (with_par && i == n - 1) begin
                bus.pro_valid = 1'b1;
                bus.pro_data  = par_vec(pbase);
            end
            @(posedge clk); #1;
        end
        bus.gen_valid = 1'b0;
        bus.pro_valid = 1'b0;
        fills_done++;
    endtask

    task automatic pulse_par(input logic [7:0] pbase);
        bus.pro_valid = 1'b1;
        bus.pro_data  = par_vec(pbase);
        @(posedge clk); #1;
        bus.pro_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) fail("drain_timeout");
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        exp_t prev;
        exp_t cur;
        exp_t e;
        bit   prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                cur.dat = bus.out_data; cur.sop = bus.out_sop; cur.eop = bus.out_eop;
                if (prev_stall) begin
                    check("stall_valid", 64'(bus.out_valid), 64'd1);
                    check("stall_hold", 64'(cur), 64'(prev));
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev       = cur;
                if (bus.out_valid && bus.out_ready) begin
                    beats_seen++;
                    if (exp_q.size() == 0) begin
                        fail("unexpected_beat");
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 64'(cur), 64'(e));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int b0;
        int t;
        bus.gen_valid     = 1'b0;
        bus.gen_data      = '0;
        bus.cfg_mes_beats = '0;
        bus.pro_valid     = 1'b0;
        bus.pro_data      = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_out_sop",   64'(bus.out_sop),   64'd0);
        check("rst_out_eop",   64'(bus.out_eop),   64'd0);
        check("rst_par_err",   64'(bus.par_err),   64'd0);
        check("rst_gen_ready", 64'(bus.gen_ready), 64'd0);
        rst = 1'b0;
        check("gen_ready_before_edge", 64'(bus.gen_ready), 64'd0);
        @(posedge clk); #1;
        check("gen_ready_after_edge", 64'(bus.gen_ready), 64'd1);

        // single codeword with hand-written expected beats
        push(32'h03020100, 1'b1, 1'b0);
        push(32'h07060504, 1'b0, 1'b0);
        push(32'h0B0A0908, 1'b0, 1'b0);
        push(32'h0F0E0D0C, 1'b0, 1'b0);
        push(32'hA4A5A6A7, 1'b0, 1'b0);
        push(32'hA0A1A2A3, 1'b0, 1'b1);
        put_msg(8'h00, 3'd4, 4, 1'b0, 8'h00);
        pulse_par(8'hA0);
        check("t1_sop_not_early", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        check("t1_sop_latency", 64'({bus.out_valid, bus.out_sop}), 64'b11);
        wait_idle();

        // three back-to-back codewords, parity 10 cycles after each fill
        f0 = fills_done;
        fork
            begin
                put_msg(8'h10, 3'd4, 4, 1'b0, 8'h00);
                put_msg(8'h40, 3'd4, 4, 1'b0, 8'h00);
                check("t2_gen_ready_both_busy", 64'(bus.gen_ready), 64'd0);
                put_msg(8'h70, 3'd4, 4, 1'b0, 8'h00);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    t = 0;
                    while (fills_done <= f0 + i && t < 400) begin
                        @(posedge clk); #1;
                        t++;
                    end
                    if (t >= 400) fail("t2_fill_timeout");
                    repeat (10) @(posedge clk);
                    #1;
                    push_cw(8'h10 + 8'(i*48), 4, 8'hB0 + 8'(i*16));
                    pulse_par(8'hB0 + 8'(i*16));
                end
            end
        join
        wait_idle();

        // random backpressure
        rand_rdy = 1'b1;
        put_msg(8'h20, 3'd4, 4, 1'b0, 8'h00);
        push_cw(8'h20, 4, 8'hE0);
        pulse_par(8'hE0);
        put_msg(8'h50, 3'd3, 3, 1'b0, 8'h00);
        push_cw(8'h50, 3, 8'hF0);
        pulse_par(8'hF0);
        put_msg(8'hC0, 3'd4, 4, 1'b0, 8'h00);
        push_cw(8'hC0, 4, 8'h18);
        pulse_par(8'h18);
        wait_idle();
        rand_rdy = 1'b0;
        @(posedge clk); #1;

        // shortened and out-of-range message lengths
        b0 = beats_seen;
        put_msg(8'h30, 3'd2, 2, 1'b0, 8'h00);
        push_cw(8'h30, 2, 8'h90);
        pulse_par(8'h90);
        put_msg(8'h60, 3'd0, 4, 1'b0, 8'h00);
        push_cw(8'h60, 4, 8'h68);
        pulse_par(8'h68);
        put_msg(8'h80, 3'd7, 4, 1'b0, 8'h00);
        push_cw(8'h80, 4, 8'h48);
        pulse_par(8'h48);
        wait_idle();
        check("t4_total_beats", 64'(beats_seen - b0), 64'd16);

        // parity with no bank waiting, then parity on the last message beat
        pulse_par(8'h11);
        check("t5_par_err_set", 64'(bus.par_err), 64'd1);
        push_cw(8'h90, 4, 8'h55);
        put_msg(8'h90, 3'd4, 4, 1'b1, 8'h55);
        check("t5_direct_full_not_early", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        check("t5_direct_full_sop", 64'({bus.out_valid, bus.out_sop}), 64'b11);
        wait_idle();
        check("t5_par_err_sticky", 64'(bus.par_err), 64'd1);

        // reset in the middle of a drain
        put_msg(8'hA0, 3'd4, 4, 1'b0, 8'h00);
        push_cw(8'hA0, 4, 8'h33);
        b0 = beats_seen;
        pulse_par(8'h33);
        t = 0;
        while (beats_seen < b0 + 3 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) fail("t6_drain_timeout");
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t6_out_valid_drop", 64'(bus.out_valid), 64'd0);
        check("t6_par_err_clear", 64'(bus.par_err), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("t6_gen_ready_in_reset", 64'(bus.gen_ready), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("t6_gen_ready_after", 64'(bus.gen_ready), 64'd1);
        put_msg(8'hC8, 3'd4, 4, 1'b0, 8'h00);
        push_cw(8'hC8, 4, 8'h77);
        pulse_par(8'h77);
        wait_idle();

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
